// File: rtl/afifo_77_wr_packer.sv
// Write-side packer for the 77-bit async FIFO: filters, length-limits and
// skid-buffers an upstream beat stream, then writes packed words into the FIFO.
module afifo_77_wr_packer #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             wr_clk,
  input  logic             wr_reset_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [63:0]      i_s_data,
  input  logic [7:0]       i_s_strb,
  input  logic             i_s_last,
  input  logic [3:0]       i_s_id,
  output logic             o_fifo_wr_en,
  output logic [76:0]      o_fifo_wr_data,
  input  logic             i_fifo_wr_full,
  input  logic             i_sts_clr,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_trunc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [8:0] LP_MAX = 9'(MAX_BEATS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_beat_cnt;
  logic [7:0]   w_beat_cnt_nxt;
  logic [3:0]   r_id_q;
  logic [3:0]   w_id_nxt;
  logic [76:0]  r_buf0;
  logic [76:0]  r_buf1;
  logic [1:0]   r_buf_cnt;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_trunc_cnt;

  logic         w_accept;
  logic         w_pop;
  logic         w_push;
  logic         w_keep;
  logic         w_pkt_inc;
  logic         w_trunc_inc;
  logic         w_word_last;
  logic [3:0]   w_word_id;
  logic [76:0]  w_word;

  assign o_s_ready      = (r_state == ST_DISCARD) | (r_buf_cnt != 2'd2);
  assign w_accept       = i_s_valid & o_s_ready;
  assign w_pop          = (r_buf_cnt != 2'd0) & ~i_fifo_wr_full;
  assign w_keep         = (i_s_strb != 8'h00) | i_s_last;
  // The first beat of a packet carries its own id; later beats reuse the latched one.
  assign w_word_id      = (r_state == ST_IDLE) ? i_s_id : r_id_q;
  assign w_word         = {w_word_id, w_word_last, i_s_strb, i_s_data};
  assign o_fifo_wr_en   = w_pop;
  assign o_fifo_wr_data = r_buf0;
  assign o_pkt_cnt      = r_pkt_cnt;
  assign o_trunc_cnt    = r_trunc_cnt;

  // Next-state and push decision for each accepted beat.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_id_nxt       = r_id_q;
    w_push         = 1'b0;
    w_word_last    = 1'b0;
    w_pkt_inc      = 1'b0;
    w_trunc_inc    = 1'b0;
    case (r_state)
      ST_IDLE, ST_BODY: begin
        if (w_accept && w_keep) begin
          w_push   = 1'b1;
          w_id_nxt = w_word_id;
          if (i_s_last) begin
            w_word_last    = 1'b1;
            w_pkt_inc      = 1'b1;
            w_beat_cnt_nxt = 8'd0;
            w_state_nxt    = ST_IDLE;
          end else if (({1'b0, r_beat_cnt} + 9'd1) == LP_MAX) begin
            w_word_last    = 1'b1;
            w_pkt_inc      = 1'b1;
            w_trunc_inc    = 1'b1;
            w_beat_cnt_nxt = 8'd0;
            w_state_nxt    = ST_DISCARD;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
            w_state_nxt    = ST_BODY;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DISCARD: begin
        if (w_accept && i_s_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, beat counter and latched packet id.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= 8'd0;
      r_id_q     <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_id_q     <= w_id_nxt;
    end
  end

  // Two-entry skid buffer; r_buf0 is always the head.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_buf0    <= 77'd0;
      r_buf1    <= 77'd0;
      r_buf_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= w_word;
          end else begin
            r_buf1 <= w_word;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf1    <= 77'd0;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= w_word;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_word;
          end
        end
        default: begin
          r_buf_cnt <= r_buf_cnt;
        end
      endcase
    end
  end

  // Saturating status counters; a clear wins over a same-cycle increment.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_pkt_cnt   <= {CNT_W{1'b0}};
      r_trunc_cnt <= {CNT_W{1'b0}};
    end else if (i_sts_clr) begin
      r_pkt_cnt   <= {CNT_W{1'b0}};
      r_trunc_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_pkt_inc) begin
        r_pkt_cnt <= sat_inc(r_pkt_cnt);
      end
      if (w_trunc_inc) begin
        r_trunc_cnt <= sat_inc(r_trunc_cnt);
      end
    end
  end

endmodule

// File: tb/tb_afifo_77_wr_packer.sv
// Bench for afifo_77_wr_packer: packet-level queue model checked every cycle,
// plus directed scenarios with hand-computed words and counter values.
module tb_afifo_77_wr_packer;
  localparam int MAXB = 4;
  localparam int CW   = 4;

  logic          wr_clk;
  logic          wr_reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic [7:0]    s_strb;
  logic          s_last;
  logic [3:0]    s_id;
  logic          wr_en;
  logic [76:0]   wr_data;
  logic          wr_full;
  logic          sts_clr;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] trunc_cnt;

  int checks   = 0;
  int failures = 0;

  afifo_77_wr_packer #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
    .i_s_strb(s_strb), .i_s_last(s_last), .i_s_id(s_id),
    .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data), .i_fifo_wr_full(wr_full),
    .i_sts_clr(sts_clr), .o_pkt_cnt(pkt_cnt), .o_trunc_cnt(trunc_cnt)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (packet rules over a word queue) ----
  logic [76:0] mq[$];
  bit          m_disc  = 1'b0;
  bit          m_inpkt = 1'b0;
  int          m_beats = 0;
  logic [3:0]  m_id    = 4'd0;
  int          m_pkt   = 0;
  int          m_trunc = 0;
  localparam int SAT = (1 << CW) - 1;

  always @(posedge wr_clk or negedge wr_reset_n) begin
    bit acc;
    bit pkt_done;
    bit trunc_done;
    logic [3:0] wid;
    if (!wr_reset_n) begin
      mq.delete();
      m_disc = 1'b0; m_inpkt = 1'b0; m_beats = 0; m_id = 4'd0;
      m_pkt = 0; m_trunc = 0;
    end else begin
      acc = s_valid && (m_disc || mq.size() < 2);
      pkt_done = 1'b0;
      trunc_done = 1'b0;
      if (mq.size() != 0 && !wr_full) void'(mq.pop_front());
      if (acc) begin
        if (m_disc) begin
          if (s_last) m_disc = 1'b0;
        end else if (s_strb != 8'h00 || s_last) begin
          wid = m_inpkt ? m_id : s_id;
          m_beats++;
          if (s_last) begin
            mq.push_back({wid, 1'b1, s_strb, s_data});
            pkt_done = 1'b1; m_inpkt = 1'b0; m_beats = 0;
          end else if (m_beats == MAXB) begin
            mq.push_back({wid, 1'b1, s_strb, s_data});
            pkt_done = 1'b1; trunc_done = 1'b1;
            m_inpkt = 1'b0; m_beats = 0; m_disc = 1'b1;
          end else begin
            mq.push_back({wid, 1'b0, s_strb, s_data});
            m_inpkt = 1'b1; m_id = wid;
          end
        end
      end
      if (sts_clr) begin
        m_pkt = 0; m_trunc = 0;
      end else begin
        if (pkt_done && m_pkt < SAT) m_pkt++;
        if (trunc_done && m_trunc < SAT) m_trunc++;
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [76:0] wlog[$];

  always @(negedge wr_clk) begin
    chk("s_ready", {76'd0, s_ready}, {76'd0, (m_disc || mq.size() < 2)});
    chk("wr_en", {76'd0, wr_en}, {76'd0, (mq.size() != 0 && !wr_full)});
    if (mq.size() != 0) chk("wr_data", wr_data, mq[0]);
    if (!wr_reset_n) chk("wr_data_rst", wr_data, 77'd0);
    chk("pkt_cnt", {73'd0, pkt_cnt}, 77'(m_pkt));
    chk("trunc_cnt", {73'd0, trunc_cnt}, 77'(m_trunc));
    if (wr_en) wlog.push_back(wr_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] st,
                           input logic lst, input logic [3:0] id);
    bit rdy;
    bit done;
    done = 1'b0;
    s_valid = 1'b1; s_data = d; s_strb = st; s_last = lst; s_id = id;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge wr_clk);
      rdy = s_ready;
      @(posedge wr_clk);
      #1;
      done = rdy;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted at %0t", $time);
    end
    s_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    sts_clr = 1'b1;
    cyc(1);
    sts_clr = 1'b0;
  endtask

  int base;

  initial begin
    wr_reset_n = 1'b0; s_valid = 1'b0; s_data = 64'd0; s_strb = 8'd0;
    s_last = 1'b0; s_id = 4'd0; wr_full = 1'b0; sts_clr = 1'b0;
    cyc(3);
    @(negedge wr_clk);
    chk("rst_ready", {76'd0, s_ready}, 77'd1);
    chk("rst_wr_en", {76'd0, wr_en}, 77'd0);
    chk("rst_data", wr_data, 77'd0);
    chk("rst_pkt", {73'd0, pkt_cnt}, 77'd0);
    @(posedge wr_clk); #1;
    wr_reset_n = 1'b1;
    cyc(2);

    // 3-beat packet, id 5
    base = wlog.size();
    send_beat(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 4'd5);
    send_beat(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 4'd5);
    send_beat(64'h1111_0000_0000_0003, 8'hFF, 1'b1, 4'd5);
    cyc(4);
    chk("t1_count", 77'(wlog.size() - base), 77'd3);
    chk("t1_w0", wlog[base],   {4'd5, 1'b0, 8'hFF, 64'h1111_0000_0000_0001});
    chk("t1_w1", wlog[base+1], {4'd5, 1'b0, 8'hFF, 64'h1111_0000_0000_0002});
    chk("t1_w2", wlog[base+2], {4'd5, 1'b1, 8'hFF, 64'h1111_0000_0000_0003});
    chk("t1_pkt", {73'd0, pkt_cnt}, 77'd1);

    // FIFO full for 10 cycles while streaming a 4-beat packet
    base = wlog.size();
    wr_full = 1'b1;
    fork
      begin
        for (int b = 0; b < 4; b++)
          send_beat(64'h2222_0000_0000_0000 + 64'(b), 8'h0F, (b == 3), 4'd2);
      end
      begin
        cyc(10);
        @(negedge wr_clk);
        chk("t2_ready_low", {76'd0, s_ready}, 77'd0);
        chk("t2_no_write", 77'(wlog.size() - base), 77'd0);
        @(posedge wr_clk); #1;
        wr_full = 1'b0;
      end
    join
    cyc(5);
    chk("t2_count", 77'(wlog.size() - base), 77'd4);
    chk("t2_w0", wlog[base],   {4'd2, 1'b0, 8'h0F, 64'h2222_0000_0000_0000});
    chk("t2_w3", wlog[base+3], {4'd2, 1'b1, 8'h0F, 64'h2222_0000_0000_0003});

    // Truncation: 7-beat packet then 2-beat packet, MAX_BEATS=4
    clr_pulse();
    base = wlog.size();
    for (int b = 0; b < 7; b++)
      send_beat(64'h3333_0000_0000_0000 + 64'(b), 8'hFF, (b == 6), 4'd1);
    send_beat(64'h4444_0000_0000_0000, 8'h01, 1'b0, 4'd4);
    send_beat(64'h4444_0000_0000_0001, 8'h03, 1'b1, 4'd4);
    cyc(4);
    chk("t3_count", 77'(wlog.size() - base), 77'd6);
    chk("t3_w2", wlog[base+2], {4'd1, 1'b0, 8'hFF, 64'h3333_0000_0000_0002});
    chk("t3_w3", wlog[base+3], {4'd1, 1'b1, 8'hFF, 64'h3333_0000_0000_0003});
    chk("t3_w4", wlog[base+4], {4'd4, 1'b0, 8'h01, 64'h4444_0000_0000_0000});
    chk("t3_w5", wlog[base+5], {4'd4, 1'b1, 8'h03, 64'h4444_0000_0000_0001});
    chk("t3_pkt", {73'd0, pkt_cnt}, 77'd2);
    chk("t3_trunc", {73'd0, trunc_cnt}, 77'd1);

    // Zero-strobe filler mid-packet and zero-strobe last marker
    base = wlog.size();
    send_beat(64'h5555_0000_0000_0000, 8'hFF, 1'b0, 4'd6);
    send_beat(64'h5555_0000_0000_0001, 8'h00, 1'b0, 4'd6);
    send_beat(64'h5555_0000_0000_0002, 8'h00, 1'b1, 4'd6);
    cyc(4);
    chk("t4_count", 77'(wlog.size() - base), 77'd2);
    chk("t4_w1", wlog[base+1], {4'd6, 1'b1, 8'h00, 64'h5555_0000_0000_0002});

    // id changes mid-packet are ignored
    base = wlog.size();
    send_beat(64'h6666_0000_0000_0000, 8'hFF, 1'b0, 4'd3);
    send_beat(64'h6666_0000_0000_0001, 8'hFF, 1'b0, 4'd9);
    send_beat(64'h6666_0000_0000_0002, 8'hFF, 1'b1, 4'd9);
    cyc(4);
    chk("t5_count", 77'(wlog.size() - base), 77'd3);
    chk("t5_w1", wlog[base+1], {4'd3, 1'b0, 8'hFF, 64'h6666_0000_0000_0001});
    chk("t5_w2", wlog[base+2], {4'd3, 1'b1, 8'hFF, 64'h6666_0000_0000_0002});

    // Reset with two buffered beats while full
    wr_full = 1'b1;
    send_beat(64'h7777_0000_0000_0000, 8'hFF, 1'b0, 4'd8);
    send_beat(64'h7777_0000_0000_0001, 8'hFF, 1'b0, 4'd8);
    cyc(2);
    base = wlog.size();
    wr_reset_n = 1'b0;
    cyc(3);
    @(negedge wr_clk);
    chk("t6_ready", {76'd0, s_ready}, 77'd1);
    chk("t6_wr_en", {76'd0, wr_en}, 77'd0);
    chk("t6_data", wr_data, 77'd0);
    chk("t6_pkt", {73'd0, pkt_cnt}, 77'd0);
    @(posedge wr_clk); #1;
    wr_reset_n = 1'b1;
    wr_full = 1'b0;
    cyc(3);
    chk("t6_no_write", 77'(wlog.size() - base), 77'd0);
    send_beat(64'h8888_0000_0000_0000, 8'hFF, 1'b0, 4'd7);
    send_beat(64'h8888_0000_0000_0001, 8'hFF, 1'b1, 4'd7);
    cyc(4);
    chk("t6_count", 77'(wlog.size() - base), 77'd2);
    chk("t6_w0", wlog[base],   {4'd7, 1'b0, 8'hFF, 64'h8888_0000_0000_0000});
    chk("t6_w1", wlog[base+1], {4'd7, 1'b1, 8'hFF, 64'h8888_0000_0000_0001});

    // Counter saturation, then clear colliding with an increment
    clr_pulse();
    for (int p = 0; p < 17; p++)
      send_beat(64'h9999_0000_0000_0000 + 64'(p), 8'h80, 1'b1, 4'(p));
    cyc(3);
    chk("t7_sat", {73'd0, pkt_cnt}, 77'd15);
    chk("t7_trunc", {73'd0, trunc_cnt}, 77'd0);
    sts_clr = 1'b1;
    send_beat(64'hAAAA_0000_0000_0000, 8'hFF, 1'b1, 4'd0);
    sts_clr = 1'b0;
    cyc(3);
    chk("t7_clr_prio", {73'd0, pkt_cnt}, 77'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
